// File: rtl/row_transfer_controller_if.sv
// Command, row-buffer read, memory-write and status signals between the row transfer controller and its neighbours.
// Latency: none, wiring only.
// Backpressure: cmd_ready throttles commands, mem_wr_ready stalls the write channel.
interface row_transfer_controller_if #(
  parameter int ADDR_WIDTH = 21
);
  logic [1:0]            command_data;
  logic                  command_data_valid;
  logic                  cmd_ready;
  logic [9:0]            mem_addr;
  logic [31:0]           pixel_data;
  logic                  mem_wr_valid;
  logic                  mem_wr_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [31:0]           mem_wr_data;
  logic                  frame_done;
  logic                  frame_buffer_id;
  logic                  seq_error;
  logic                  busy;

  // Controller side
  modport master (
    input  command_data, command_data_valid, pixel_data, mem_wr_ready,
    output cmd_ready, mem_addr, mem_wr_valid, mem_wr_addr, mem_wr_data,
           frame_done, frame_buffer_id, seq_error, busy
  );

  // Environment side: command source, row buffer, memory, display reader
  modport slave (
    output command_data, command_data_valid, pixel_data, mem_wr_ready,
    input  cmd_ready, mem_addr, mem_wr_valid, mem_wr_addr, mem_wr_data,
           frame_done, frame_buffer_id, seq_error, busy
  );
endinterface

// File: rtl/row_transfer_controller.sv
// Copies each ready row from the line buffer into one of two frame buffers in external memory.
// Latency: 3 cycles per word minimum (read address, read data, write), plus 1 cycle at each row end.
// Backpressure: a stalled write holds valid/addr/data; commands are refused (cmd_ready low) during a row transfer.
module row_transfer_controller #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 21,
  parameter int FRAME_STRIDE = 'h40000
) (
  input logic                       clk_mem,
  input logic                       reset_n,
  row_transfer_controller_if.master bus
);
  localparam int WORDS_PER_ROW = FRAME_WIDTH / 2;
  localparam int WORD_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROW_W         = $clog2(FRAME_HEIGHT + 1);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LIMIT = ROW_W'(FRAME_HEIGHT);

  localparam logic [1:0] CMD_FRAME_START = 2'd1;
  localparam logic [1:0] CMD_ROW_READY   = 2'd2;
  localparam logic [1:0] CMD_FRAME_END   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    RD_ADDR,
    RD_DATA,
    WR,
    ROW_END
  } state_t;

  state_t              state;
  logic [ROW_W-1:0]    row;
  logic [WORD_W-1:0]   word;
  logic                wbuf;

  logic                cmd_take;
  logic [WORD_W-1:0]   word_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_calc;

  assign cmd_take = bus.command_data_valid & bus.cmd_ready;
  assign word_nxt = word + 1'b1;

  // Frame buffer base plus linear pixel-word offset; overflow wraps at the address width.
  assign wr_addr_calc = (wbuf ? ADDR_WIDTH'(FRAME_STRIDE) : '0)
                      + ADDR_WIDTH'(int'(row) * WORDS_PER_ROW)
                      + ADDR_WIDTH'(word);

  // Transfer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      bus.cmd_ready       <= 1'b1;
      bus.mem_wr_valid    <= 1'b0;
      bus.frame_done      <= 1'b0;
      bus.seq_error       <= 1'b0;
      bus.busy            <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wr_addr     <= '0;
      bus.mem_wr_data     <= '0;
      bus.frame_buffer_id <= 1'b0;
      row                 <= '0;
      word                <= '0;
      wbuf                <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.seq_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_take) begin
            case (bus.command_data)
              CMD_FRAME_START: begin
                // Write into the buffer the display is not reading.
                row      <= '0;
                wbuf     <= ~bus.frame_buffer_id;
                bus.busy <= 1'b1;
                state    <= FRAME;
              end
              CMD_ROW_READY, CMD_FRAME_END: bus.seq_error <= 1'b1;
              default: ;
            endcase
          end
        end
        FRAME: begin
          if (cmd_take) begin
            case (bus.command_data)
              CMD_FRAME_START: begin
                // Restart the frame in the same buffer.
                bus.seq_error <= 1'b1;
                row           <= '0;
              end
              CMD_ROW_READY: begin
                if (row < ROW_LIMIT) begin
                  // mem_addr is presented for the whole RD_ADDR cycle.
                  word          <= '0;
                  bus.mem_addr  <= '0;
                  bus.cmd_ready <= 1'b0;
                  state         <= RD_ADDR;
                end else begin
                  bus.seq_error <= 1'b1;
                end
              end
              CMD_FRAME_END: begin
                // Short frames are published as-is.
                bus.frame_done      <= 1'b1;
                bus.frame_buffer_id <= wbuf;
                bus.busy            <= 1'b0;
                state               <= IDLE;
              end
              default: ;
            endcase
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          bus.mem_wr_data  <= bus.pixel_data;
          bus.mem_wr_addr  <= wr_addr_calc;
          bus.mem_wr_valid <= 1'b1;
          state            <= WR;
        end
        WR: begin
          if (bus.mem_wr_ready) begin
            bus.mem_wr_valid <= 1'b0;
            if (word == LAST_WORD) begin
              state <= ROW_END;
            end else begin
              word         <= word_nxt;
              bus.mem_addr <= 10'(word_nxt);
              state        <= RD_ADDR;
            end
          end
        end
        ROW_END: begin
          row           <= row + 1'b1;
          bus.cmd_ready <= 1'b1;
          state         <= FRAME;
        end
        default: begin
          bus.cmd_ready    <= 1'b1;
          bus.mem_wr_valid <= 1'b0;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_row_transfer_controller.sv
// Randomised scoreboard bench: a command-level model predicts writes and status pulses, a monitor checks them.
// Latency: the row-buffer model returns data one cycle after the address.
// Backpressure: mem_wr_ready is driven always-high, randomly, or with targeted stalls.
module tb_row_transfer_controller;
  localparam int FW     = 24;
  localparam int FH     = 8;
  localparam int AW     = 10;
  localparam int STRIDE = 'h3C0;
  localparam int W      = FW / 2;

  localparam int EV_ERR   = 1;
  localparam int EV_DONE0 = 2;
  localparam int EV_DONE1 = 3;

  logic clk_mem = 1'b0;
  logic reset_n = 1'b0;

  // 10 ns clock
  always #5 clk_mem = ~clk_mem;

  row_transfer_controller_if #(.ADDR_WIDTH(AW)) bus ();

  row_transfer_controller #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .ADDR_WIDTH  (AW),
    .FRAME_STRIDE(STRIDE)
  ) dut (
    .clk_mem(clk_mem),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] rowbuf [1024];
  wr_t         wr_q [$];
  int          ev_q [$];

  // Command-level reference model state
  bit m_in_frame = 1'b0;
  int m_row      = 0;
  bit m_wbuf     = 1'b0;
  bit m_fbid     = 1'b0;

  // Write-channel backpressure controls
  int            stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input bit b, input int r, input int w);
    int a;
    a = (b ? STRIDE : 0) + r * W + w;
    return AW'(a % (1 << AW));
  endfunction

  // Apply the command rules to the model at the moment a command is accepted.
  task automatic model_accept(input logic [1:0] c);
    wr_t e;
    if (c == 2'd0) return;
    if (!m_in_frame) begin
      if (c == 2'd1) begin
        m_in_frame = 1'b1;
        m_row      = 0;
        m_wbuf     = !m_fbid;
      end else begin
        ev_q.push_back(EV_ERR);
      end
    end else begin
      case (c)
        2'd1: begin
          ev_q.push_back(EV_ERR);
          m_row = 0;
        end
        2'd2: begin
          if (m_row < FH) begin
            for (int w = 0; w < W; w++) begin
              e.addr = exp_addr(m_wbuf, m_row, w);
              e.data = rowbuf[w];
              wr_q.push_back(e);
            end
            m_row++;
          end else begin
            ev_q.push_back(EV_ERR);
          end
        end
        default: begin
          ev_q.push_back(m_wbuf ? EV_DONE1 : EV_DONE0);
          m_fbid     = m_wbuf;
          m_in_frame = 1'b0;
        end
      endcase
    end
  endtask

  // Called and returns at posedge+2.
  task automatic send_cmd(input logic [1:0] c);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 5000) begin
      @(posedge clk_mem); #2;
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      chk("cmd_ready_timeout", {63'd0, bus.cmd_ready}, 64'd1);
      return;
    end
    if (c == 2'd2) begin
      for (int i = 0; i < W; i++) rowbuf[i] = $urandom;
    end
    bus.command_data       = c;
    bus.command_data_valid = 1'b1;
    @(posedge clk_mem);
    model_accept(c);
    #2;
    bus.command_data_valid = 1'b0;
    bus.command_data       = 2'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_mem); #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},    {63'd0, bus.cmd_ready},       64'd1);
    chk({tag, "_mem_wr_valid"}, {63'd0, bus.mem_wr_valid},    64'd0);
    chk({tag, "_frame_done"},   {63'd0, bus.frame_done},      64'd0);
    chk({tag, "_seq_error"},    {63'd0, bus.seq_error},       64'd0);
    chk({tag, "_busy"},         {63'd0, bus.busy},            64'd0);
    chk({tag, "_mem_addr"},     {54'd0, bus.mem_addr},        64'd0);
    chk({tag, "_mem_wr_addr"},  {54'd0, bus.mem_wr_addr},     64'd0);
    chk({tag, "_mem_wr_data"},  {32'd0, bus.mem_wr_data},     64'd0);
    chk({tag, "_fb_id"},        {63'd0, bus.frame_buffer_id}, 64'd0);
  endtask

  // Row buffer: synchronous read, data one cycle after the address.
  initial begin
    logic [9:0] a;
    bus.pixel_data = '0;
    forever begin
      @(negedge clk_mem);
      a = bus.mem_addr;
      @(posedge clk_mem); #1;
      bus.pixel_data = rowbuf[a];
    end
  end

  // Memory write-ready driver.
  initial begin
    bus.mem_wr_ready = 1'b1;
    forever begin
      @(posedge clk_mem); #2;
      if (stall_left > 0 && bus.mem_wr_valid && bus.mem_wr_addr == stall_addr) begin
        bus.mem_wr_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        bus.mem_wr_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.mem_wr_ready = 1'b1;
      end
    end
  end

  // Monitor: compares write handshakes and status pulses against the scoreboard queues.
  initial begin
    bit            pstall;
    logic [AW-1:0] paddr;
    logic [31:0]   pdata;
    wr_t           e;
    int            ev;
    pstall = 1'b0;
    paddr  = '0;
    pdata  = '0;
    forever begin
      @(negedge clk_mem);
      if (!reset_n) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          chk("stall_valid_held", {63'd0, bus.mem_wr_valid}, 64'd1);
          chk("stall_addr_held",  {54'd0, bus.mem_wr_addr},  {54'd0, paddr});
          chk("stall_data_held",  {32'd0, bus.mem_wr_data},  {32'd0, pdata});
        end
        if (bus.mem_wr_valid) begin
          chk("cmd_ready_during_xfer", {63'd0, bus.cmd_ready}, 64'd0);
          if (bus.mem_wr_ready) begin
            if (wr_q.size() == 0) begin
              chk("unexpected_write", {54'd0, bus.mem_wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              e = wr_q.pop_front();
              chk("wr_addr", {54'd0, bus.mem_wr_addr}, {54'd0, e.addr});
              chk("wr_data", {32'd0, bus.mem_wr_data}, {32'd0, e.data});
            end
          end
        end
        pstall = bus.mem_wr_valid && !bus.mem_wr_ready;
        paddr  = bus.mem_wr_addr;
        pdata  = bus.mem_wr_data;
        if (bus.seq_error) begin
          ev = (ev_q.size() > 0) ? ev_q.pop_front() : 0;
          chk("seq_error_event", 64'(ev), 64'(EV_ERR));
        end
        if (bus.frame_done) begin
          ev = (ev_q.size() > 0) ? ev_q.pop_front() : 0;
          chk("frame_done_event", 64'(ev), 64'(EV_DONE0 + int'(bus.frame_buffer_id)));
        end
      end
    end
  end

  // Hard stop if anything wedges.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    int r;
    bus.command_data       = 2'd0;
    bus.command_data_valid = 1'b0;
    for (int i = 0; i < 1024; i++) rowbuf[i] = '0;

    // Reset values, held and just after release
    repeat (3) @(posedge clk_mem);
    #2;
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    idle_cycles(1);
    check_reset_outputs("after_release");

    // First frame into buffer 1; one row with ready always high, timed
    send_cmd(2'd1);
    chk("busy_in_frame", {63'd0, bus.busy}, 64'd1);
    send_cmd(2'd2);
    n = 1;
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      @(posedge clk_mem); #2;
      n++;
    end
    chk("row_cycles", 64'(n - 1), 64'(3 * W + 1));

    // Five-cycle stall on word 7
    stall_addr = exp_addr(m_wbuf, m_row, 7);
    stall_left = 5;
    send_cmd(2'd2);
    send_cmd(2'd0);
    chk("stall_cycles_consumed", 64'(stall_left), 64'd0);

    // Rest of the frame with random backpressure, overflow row, then frame end
    rand_ready = 1'b1;
    while (m_row < FH) send_cmd(2'd2);
    send_cmd(2'd2);
    send_cmd(2'd3);
    idle_cycles(2);
    chk("fb_id_after_full_frame", {63'd0, bus.frame_buffer_id}, 64'd1);

    // Protocol violations while idle
    send_cmd(2'd2);
    send_cmd(2'd3);
    send_cmd(2'd0);

    // Next frame from base 0; restart mid-frame; short frame end
    send_cmd(2'd1);
    for (int i = 0; i < 3; i++) send_cmd(2'd2);
    send_cmd(2'd1);
    send_cmd(2'd2);
    send_cmd(2'd3);
    idle_cycles(2);
    chk("fb_id_after_short_frame", {63'd0, bus.frame_buffer_id}, 64'd0);

    // Random command stream
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      send_cmd(2'd0);
      else if (r == 1) send_cmd(2'd1);
      else if (r < 8)  send_cmd(2'd2);
      else             send_cmd(2'd3);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset while a write is stalled on word 5
    rand_ready = 1'b0;
    send_cmd(2'd1);
    if (m_row >= FH) send_cmd(2'd1);
    stall_addr = exp_addr(m_wbuf, m_row, 5);
    stall_left = 1000;
    send_cmd(2'd2);
    n = 0;
    while (!(bus.mem_wr_valid === 1'b1 && bus.mem_wr_addr == stall_addr) && n < 500) begin
      @(posedge clk_mem); #2;
      n++;
    end
    chk("reached_stalled_word", {63'd0, bus.mem_wr_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_xfer_reset");
    stall_left = 0;
    wr_q.delete();
    m_in_frame = 1'b0;
    m_row      = 0;
    m_wbuf     = 1'b0;
    m_fbid     = 1'b0;
    @(posedge clk_mem); #2;
    reset_n = 1'b1;
    idle_cycles(1);
    send_cmd(2'd2);

    // Drain and confirm nothing expected is still outstanding
    idle_cycles(10);
    chk("writes_outstanding", 64'(wr_q.size()), 64'd0);
    chk("events_outstanding", 64'(ev_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
